// File: rtl/counter_stim_gen.sv
// Stimulus generator for an up/down loadable counter: runs load, count-up, hold and
// count-down phases, and checks the fed-back counter value against its own model.
module counter_stim_gen #(
    parameter int unsigned CW = 16,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] load_val,
    input  logic [LW-1:0] up_len,
    input  logic [LW-1:0] hold_len,
    input  logic [LW-1:0] dn_len,
    input  logic [CW-1:0] cnt_q,
    output logic [CW-1:0] data_in,
    output logic          ld_cnt,
    output logic          updn_cnt,
    output logic          count_enb,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [LW-1:0] err_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StUp,
        StHold,
        StDown,
        StFin
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] phase_q, phase_d;
    logic [CW-1:0] load_q;
    logic [LW-1:0] up_q, hold_q, dn_q;
    logic [CW-1:0] exp_q, exp_d;
    logic          err_q;
    logic [LW-1:0] err_cnt_q;

    logic [LW-1:0] cur_len;
    logic          phase_last;
    logic          cmp_active;
    logic          mismatch;
    state_e        next_from_load, next_from_up, next_from_hold;

    // Zero-length phases are skipped by jumping straight to the next non-empty one.
    always_comb begin
        next_from_hold = (dn_q != '0) ? StDown : StFin;
        next_from_up   = (hold_q != '0) ? StHold : next_from_hold;
        next_from_load = (up_q != '0) ? StUp : next_from_up;
    end

    always_comb begin
        cur_len = '0;
        unique case (state_q)
            StUp:    cur_len = up_q;
            StHold:  cur_len = hold_q;
            StDown:  cur_len = dn_q;
            default: cur_len = '0;
        endcase
    end

    assign phase_last = (phase_q == (cur_len - LW'(1)));

    // Next state and counter controls.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        data_in   = '0;
        ld_cnt    = 1'b1;
        updn_cnt  = 1'b1;
        count_enb = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy    = 1'b0;
                phase_d = '0;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                ld_cnt  = 1'b0;
                data_in = load_q;
                phase_d = '0;
                state_d = next_from_load;
            end
            StUp: begin
                count_enb = 1'b1;
                if (phase_last) begin
                    state_d = next_from_up;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + LW'(1);
                end
            end
            StHold: begin
                if (phase_last) begin
                    state_d = next_from_hold;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + LW'(1);
                end
            end
            StDown: begin
                count_enb = 1'b1;
                updn_cnt  = 1'b0;
                if (phase_last) begin
                    state_d = StFin;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + LW'(1);
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
                busy    = 1'b0;
            end
        endcase
    end

    // Expected counter value mirrors an ideal counter and never resyncs to cnt_q.
    always_comb begin
        exp_d = exp_q;
        unique case (state_q)
            StLoad:  exp_d = load_q;
            StUp:    exp_d = exp_q + CW'(1);
            StDown:  exp_d = exp_q - CW'(1);
            default: exp_d = exp_q;
        endcase
    end

    assign cmp_active = (state_q == StUp) || (state_q == StHold) ||
                        (state_q == StDown) || (state_q == StFin);
    assign mismatch   = cmp_active && (cnt_q != exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q    <= '0;
            up_q      <= '0;
            hold_q    <= '0;
            dn_q      <= '0;
            exp_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            exp_q <= exp_d;
            if (state_q == StIdle && start) begin
                load_q    <= load_val;
                up_q      <= up_len;
                hold_q    <= hold_len;
                dn_q      <= dn_len;
                err_q     <= 1'b0;
                err_cnt_q <= '0;
            end else if (mismatch) begin
                err_q <= 1'b1;
                if (err_cnt_q != {LW{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + LW'(1);
                end
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_counter_stim_gen.sv
// Bench for counter_stim_gen: a behavioural counter closes the loop, and a scoreboard
// checks the counter trace and end-of-sequence results against hand-computed values.
module tb_counter_stim_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] load_val;
    logic [7:0]  up_len, hold_len, dn_len;
    logic [15:0] cnt_q = '0;
    logic [15:0] data_in;
    logic        ld_cnt, updn_cnt, count_enb, busy, done, err;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic [15:0] cnt;
        logic [7:0]  busy_len;
        logic        err;
        logic [7:0]  err_cnt;
    } res_t;

    res_t        res_q[$];
    logic [15:0] seq_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          seq_chk = 1'b1;
    bit          fault_skip = 1'b0;
    bit          skip_armed = 1'b0;

    counter_stim_gen #(.CW(16), .LW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_val  (load_val),
        .up_len    (up_len),
        .hold_len  (hold_len),
        .dn_len    (dn_len),
        .cnt_q     (cnt_q),
        .data_in   (data_in),
        .ld_cnt    (ld_cnt),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural counter; fault mode drops the first count-up step after a load.
    always @(posedge clk) begin
        if (!ld_cnt) begin
            cnt_q      <= data_in;
            skip_armed <= fault_skip;
        end else if (count_enb) begin
            if (updn_cnt && skip_armed) skip_armed <= 1'b0;
            else if (updn_cnt) cnt_q <= cnt_q + 16'd1;
            else cnt_q <= cnt_q - 16'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ld_cnt"}, ld_cnt, 1);
        chk({tag, "_count_enb"}, count_enb, 0);
        chk({tag, "_updn_cnt"}, updn_cnt, 1);
        chk({tag, "_data_in"}, data_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    task automatic exp_res(input logic [15:0] c, input logic [7:0] bl, input logic e,
                           input logic [7:0] ec);
        res_t r;
        r.cnt = c; r.busy_len = bl; r.err = e; r.err_cnt = ec;
        res_q.push_back(r);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 200 cycles");
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Length inputs are scrambled while busy; the captured values must be used.
    task automatic run_seq(input logic [15:0] lv, input logic [7:0] u, input logic [7:0] h,
                           input logic [7:0] d, input bit glitch);
        @(negedge clk);
        load_val = lv; up_len = u; hold_len = h; dn_len = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; load_val = 16'hA5A5; up_len = 8'hFF; hold_len = 8'hFF; dn_len = 8'hFF;
        if (glitch) begin
            @(negedge clk);
            start = 1'b1; load_val = 16'hBEEF;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    // Monitor: checks counter trace each busy non-load cycle, results at done.
    initial begin
        int   busy_run = 0;
        bit   pend = 1'b0;
        res_t pend_r;
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("err", err, pend_r.err);
                    chk("err_cnt", err_cnt, pend_r.err_cnt);
                    pend = 1'b0;
                end
                if (busy) busy_run++;
                if (busy && ld_cnt && seq_chk) begin
                    if (seq_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL cnt_seq: got cnt_q %0h, expected no compare", cnt_q);
                    end else begin
                        chk("cnt_seq", cnt_q, seq_q.pop_front());
                    end
                end
                if (done) begin
                    if (res_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL done_unexpected: got done, expected none");
                    end else begin
                        r = res_q.pop_front();
                        chk("final_cnt", cnt_q, r.cnt);
                        chk("busy_len", busy_run, r.busy_len);
                        pend = 1'b1;
                        pend_r = r;
                    end
                    busy_run = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; load_val = '0; up_len = '0; hold_len = '0; dn_len = '0;
        #1 check_idle("por");
        @(negedge clk);
        rst = 1'b0;

        // Nominal: 0x10 up3 hold2 dn5
        seq_q.push_back(16'h0010); seq_q.push_back(16'h0011); seq_q.push_back(16'h0012);
        seq_q.push_back(16'h0013); seq_q.push_back(16'h0013);
        seq_q.push_back(16'h0013); seq_q.push_back(16'h0012); seq_q.push_back(16'h0011);
        seq_q.push_back(16'h0010); seq_q.push_back(16'h000F);
        seq_q.push_back(16'h000E);
        exp_res(16'h000E, 8'd12, 1'b0, 8'd0);
        run_seq(16'h0010, 8'd3, 8'd2, 8'd5, 1'b0);

        // Wrap both ways
        seq_q.push_back(16'hFFFE); seq_q.push_back(16'hFFFF); seq_q.push_back(16'h0000);
        seq_q.push_back(16'h0001); seq_q.push_back(16'h0000);
        seq_q.push_back(16'hFFFF);
        exp_res(16'hFFFF, 8'd7, 1'b0, 8'd0);
        run_seq(16'hFFFE, 8'd3, 8'd0, 8'd2, 1'b0);

        // All phases empty
        seq_q.push_back(16'h1234);
        exp_res(16'h1234, 8'd2, 1'b0, 8'd0);
        run_seq(16'h1234, 8'd0, 8'd0, 8'd0, 1'b0);

        // Faulty counter drops first up step: three mismatches, no resync
        fault_skip = 1'b1;
        seq_q.push_back(16'h0100); seq_q.push_back(16'h0100); seq_q.push_back(16'h0101);
        seq_q.push_back(16'h0102);
        exp_res(16'h0102, 8'd5, 1'b1, 8'd3);
        run_seq(16'h0100, 8'd3, 8'd0, 8'd0, 1'b0);
        fault_skip = 1'b0;

        // Async reset in idle clears the sticky error without a clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle("idle_rst");
        @(negedge clk);
        rst = 1'b0;

        // start pulsed during UP must be ignored
        seq_q.push_back(16'h0040); seq_q.push_back(16'h0041); seq_q.push_back(16'h0042);
        seq_q.push_back(16'h0043); seq_q.push_back(16'h0044);
        seq_q.push_back(16'h0044); seq_q.push_back(16'h0043);
        seq_q.push_back(16'h0042);
        exp_res(16'h0042, 8'd9, 1'b0, 8'd0);
        run_seq(16'h0040, 8'd4, 8'd1, 8'd2, 1'b1);

        // Reset mid-DOWN returns to idle before the next edge
        seq_chk = 1'b0;
        @(negedge clk);
        load_val = 16'h0020; up_len = 8'd2; hold_len = 8'd0; dn_len = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(busy === 1'b1 && updn_cnt === 1'b0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reached_down", (k < 50), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle("mid_down_rst");
        @(negedge clk);
        rst = 1'b0;
        seq_chk = 1'b1;

        // Fresh sequence after reset
        seq_q.push_back(16'h0005); seq_q.push_back(16'h0006); seq_q.push_back(16'h0006);
        seq_q.push_back(16'h0005);
        exp_res(16'h0005, 8'd5, 1'b0, 8'd0);
        run_seq(16'h0005, 8'd1, 8'd1, 8'd1, 1'b0);

        chk("res_q_drained", res_q.size(), 0);
        chk("seq_q_drained", seq_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_stim_gen.md
COUNTER_STIM_GEN -- requirements
Module: counter_stim_gen

Interface
REQ-001 Parameter: CW, default 16, counter data width.
REQ-002 Parameter: LW, default 8, width of each phase-length field.
REQ-003 Ports, clock and reset first:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to run one sequence.
- load_val  in  CW  value to load into the counter.
- up_len  in  LW  number of count-up cycles.
- hold_len  in  LW  number of hold cycles.
- dn_len  in  LW  number of count-down cycles.
- cnt_q  in  CW  counter output (counter data_out) fed back.
- data_in  out  CW  counter load data.
- ld_cnt  out  1  counter load, active-low.
- updn_cnt  out  1  counter direction: 1 up, 0 down.
- count_enb  out  1  counter enable, active-high.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle end-of-sequence pulse.
- err  out  1  sticky mismatch flag.
- err_cnt  out  LW  mismatch count.
REQ-004 The generator SHALL drive a counter with this behaviour: it loads data_in when ld_cnt=0; otherwise it steps ±1 per updn_cnt when count_enb=1; otherwise it holds.

Function
REQ-005 FSM states SHALL be IDLE, LOAD, UP, HOLD, DOWN, FIN.
REQ-006 IDLE outputs SHALL be: ld_cnt=1, count_enb=0, updn_cnt=1, data_in=0, busy=0, done=0.
REQ-007 In IDLE, start=1 at a posedge SHALL capture load_val, up_len, hold_len, dn_len; clear err and err_cnt; and enter LOAD.
REQ-008 start SHALL be ignored in every state other than IDLE.
REQ-009 LOAD SHALL last 1 cycle with ld_cnt=0, count_enb=0, data_in=captured load_val; the expected register exp SHALL be set to load_val at its exit edge.
REQ-010 Phase order SHALL be LOAD, UP, HOLD, DOWN, FIN; any phase with captured length 0 SHALL be skipped.
REQ-011 UP SHALL last up_len cycles with ld_cnt=1, count_enb=1, updn_cnt=1, and exp SHALL increment each edge.
REQ-012 HOLD SHALL last hold_len cycles with ld_cnt=1, count_enb=0, and exp SHALL hold.
REQ-013 DOWN SHALL last dn_len cycles with ld_cnt=1, count_enb=1, updn_cnt=0, and exp SHALL decrement each edge.
REQ-014 FIN SHALL last 1 cycle with IDLE-valued counter controls and done=1, then return to IDLE.
REQ-015 busy SHALL be 1 in LOAD, UP, HOLD, DOWN and FIN.
REQ-016 exp arithmetic SHALL be modulo 2^CW: FFFF+1=0000 and 0000-1=FFFF.
REQ-017 In every cycle in UP, HOLD, DOWN or FIN, cnt_q SHALL be compared with exp. On mismatch, err SHALL be set at the next edge and err_cnt SHALL increment, saturating at 2^LW-1.
REQ-018 exp SHALL never resynchronize to cnt_q, so a persistent fault is counted on every subsequent compare.
REQ-019 Phase length counters SHALL be LW bits wide and compare against the captured values; changes to the length inputs while busy SHALL have no effect.

Reset
REQ-020 rst=1 SHALL force IDLE immediately, without waiting for clk, including mid-sequence.
REQ-021 Under reset, outputs SHALL be: ld_cnt=1, count_enb=0, updn_cnt=1, data_in=0, busy=0, done=0, err=0, err_cnt=0; exp SHALL be 0.
REQ-022 After rst deasserts, the first accepted start SHALL behave identically to a sequence started from power-up.

Verification
REQ-023 Reset: rst=1 at any state -> all outputs at REQ-021 values before the next clk edge.
REQ-024 load_val=0x0010, up=3, hold=2, dn=5, with an ideal counter -> busy for 12 cycles; done in cycle 12; final cnt_q=0x000E; err=0.
REQ-025 Wrap: load_val=0xFFFE, up=3, hold=0, dn=2 -> cnt_q sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0000, 0xFFFF; err=0.
REQ-026 All lengths 0, load_val=0x1234 -> LOAD then FIN; busy for 2 cycles; cnt_q=0x1234 at FIN; err=0.
REQ-027 Faulty counter that ignores the first UP edge, with up=3, hold=0, dn=0 -> err=1 and err_cnt=3.
REQ-028 start pulsed while in UP -> ignored; rst mid-DOWN -> IDLE immediately; a new start then completes with err=0.
